regfile_mp: RTL and testbench

Parametrised multi-port register file for the CPU decode/writeback stages, and the successor to the fixed 32×32, 1-write/2-read register file. It provides configurable width, depth and read/write port counts, with register 0 hardwired to zero. It adds same-cycle write-to-read bypass, an optional registered-read pipeline stage, and a per-register pending-write scoreboard that the hazard unit uses for stall decisions.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_read_port.sv | 56 +++++
 rtl/regfile_mp.sv | 74 +++++++
 tb/tb_regfile_mp.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, read/bypass mode constants and packed-bus slicing helper
package regfile_pkg;
  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int RD_COMB = 0;
  localparam int RD_REG  = 1;
  localparam int BYP_OFF = 0;
  localparam int BYP_ON  = 1;
  function automatic int slice_base(input int idx, input int width);
    return idx * width;
  endfunction
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one read port (index decode, write bypass, optional output register); ports clk/rst, addr_i, write bus, reserve, store_i/pend_i in, data_o/pend_o out
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DW       = DEF_DATA_WIDTH,
  parameter int NR       = DEF_NUM_REGS,
  parameter int AW       = $clog2(NR),
  parameter int NW       = 2,
  parameter int REG_READ = RD_COMB,
  parameter int BYPASS   = BYP_ON
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    addr_i,
  input  logic [NW-1:0]    we_i,
  input  logic [NW*AW-1:0] wreg_i,
  input  logic [NW*DW-1:0] wdata_i,
  input  logic             rsv_i,
  input  logic [AW-1:0]    rsv_reg_i,
  input  logic [NR*DW-1:0] store_i,
  input  logic [NR-1:0]    pend_i,
  output logic [DW-1:0]    data_o,
  output logic             pend_o
);
  logic [DW-1:0] data_d;
  logic          pend_d;
  always_comb begin
    data_d = (addr_i == '0) ? '0 : store_i[slice_base(int'(addr_i), DW) +: DW];
    pend_d = pend_i[addr_i];
    if (BYPASS == BYP_ON)
      for (int i = 0; i < NW; i++)
        if (we_i[i] && addr_i != '0 && wreg_i[slice_base(i, AW) +: AW] == addr_i) begin
          data_d = wdata_i[slice_base(i, DW) +: DW];
          pend_d = (rsv_i && rsv_reg_i == addr_i) ? pend_d : 1'b0;
        end
  end
  generate
    if (REG_READ == RD_REG) begin : g_reg
      logic [DW-1:0] data_q;
      logic          pend_q;
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          data_q <= '0;
          pend_q <= 1'b0;
        end else begin
          data_q <= data_d;
          pend_q <= pend_d;
        end
      assign data_o = data_q;
      assign pend_o = pend_q;
    end else begin : g_comb
      assign data_o = data_d;
      assign pend_o = pend_d;
    end
  endgenerate
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file, r0 = 0, bypass, optional registered read, pending-write scoreboard; ports clock/ctrl_reset, write/reserve/read buses in, read data, pending and debug dump out
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2,
  parameter int REG_READ   = RD_COMB,
  parameter int BYPASS     = BYP_ON
) (
  input  logic                            clock,
  input  logic                            ctrl_reset,
  input  logic [NUM_WRITE-1:0]            ctrl_writeEnable,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] ctrl_writeReg,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] data_writeReg,
  input  logic                            ctrl_reserve,
  input  logic [ADDR_WIDTH-1:0]           ctrl_reserveReg,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  ctrl_readReg,
  output logic [NUM_READ*DATA_WIDTH-1:0]  data_readReg,
  output logic [NUM_READ-1:0]             read_pending,
  output logic [NUM_REGS-1:0]             pending_vec,
  output logic [NUM_REGS*DATA_WIDTH-1:0]  reg_dump
);
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   pend_q, pend_d;
  // ascending port order makes the highest-numbered port win a collision
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    for (int i = 0; i < NUM_WRITE; i++)
      if (ctrl_writeEnable[i] && ctrl_writeReg[slice_base(i, ADDR_WIDTH) +: ADDR_WIDTH] != '0) begin
        regs_d[ctrl_writeReg[slice_base(i, ADDR_WIDTH) +: ADDR_WIDTH]] = data_writeReg[slice_base(i, DATA_WIDTH) +: DATA_WIDTH];
        pend_d[ctrl_writeReg[slice_base(i, ADDR_WIDTH) +: ADDR_WIDTH]] = 1'b0;
      end
    if (ctrl_reserve && ctrl_reserveReg != '0) pend_d[ctrl_reserveReg] = 1'b1;
  end
  always_ff @(posedge clock or posedge ctrl_reset)
    if (ctrl_reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  assign pending_vec = pend_q;
  genvar r, k;
  generate
    for (r = 0; r < NUM_REGS; r++) begin : g_dump
      assign reg_dump[r*DATA_WIDTH +: DATA_WIDTH] = regs_q[r];
    end
    for (k = 0; k < NUM_READ; k++) begin : g_rd
      regfile_read_port #(
        .DW(DATA_WIDTH), .NR(NUM_REGS), .AW(ADDR_WIDTH), .NW(NUM_WRITE),
        .REG_READ(REG_READ), .BYPASS(BYPASS)
      ) u_rd (
        .clk      (clock),
        .rst      (ctrl_reset),
        .addr_i   (ctrl_readReg[k*ADDR_WIDTH +: ADDR_WIDTH]),
        .we_i     (ctrl_writeEnable),
        .wreg_i   (ctrl_writeReg),
        .wdata_i  (data_writeReg),
        .rsv_i    (ctrl_reserve),
        .rsv_reg_i(ctrl_reserveReg),
        .store_i  (reg_dump),
        .pend_i   (pend_q),
        .data_o   (data_readReg[k*DATA_WIDTH +: DATA_WIDTH]),
        .pend_o   (read_pending[k])
      );
    end
  endgenerate
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scoreboard bench over three regfile_mp configurations
module tb_regfile_mp;
  logic         clock = 1'b0;
  logic         ctrl_reset = 1'b1;
  logic [1:0]   we = '0;
  logic [9:0]   wreg = '0;
  logic [63:0]  wdata = '0;
  logic         rsv = 1'b0;
  logic [4:0]   rsv_reg = '0;
  logic [9:0]   rreg = '0;
  logic [63:0]  rd_a, rd_b, rd_c;
  logic [1:0]   rp_a, rp_b, rp_c;
  logic [31:0]  pv_a, pv_b, pv_c;
  logic [1023:0] dump_a, dump_b, dump_c;
  logic [31:0]  exp_q [$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  regfile_mp #(.REG_READ(0), .BYPASS(1)) dut_a (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(we), .ctrl_writeReg(wreg),
    .data_writeReg(wdata), .ctrl_reserve(rsv), .ctrl_reserveReg(rsv_reg), .ctrl_readReg(rreg),
    .data_readReg(rd_a), .read_pending(rp_a), .pending_vec(pv_a), .reg_dump(dump_a));
  regfile_mp #(.REG_READ(0), .BYPASS(0)) dut_b (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(we), .ctrl_writeReg(wreg),
    .data_writeReg(wdata), .ctrl_reserve(rsv), .ctrl_reserveReg(rsv_reg), .ctrl_readReg(rreg),
    .data_readReg(rd_b), .read_pending(rp_b), .pending_vec(pv_b), .reg_dump(dump_b));
  regfile_mp #(.REG_READ(1), .BYPASS(1)) dut_c (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(we), .ctrl_writeReg(wreg),
    .data_writeReg(wdata), .ctrl_reserve(rsv), .ctrl_reserveReg(rsv_reg), .ctrl_readReg(rreg),
    .data_readReg(rd_c), .read_pending(rp_c), .pending_vec(pv_c), .reg_dump(dump_c));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      n_vec++;
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    we[p] = 1'b1;
    wreg[p*5 +: 5] = a;
    wdata[p*32 +: 32] = d;
  endtask

  initial begin
    #12 ctrl_reset = 1'b0;
    tick();
    for (int i = 0; i < 32; i++) begin
      rreg = {5'(31 - i), 5'(i)};
      #1;
      exp_q.push_back(32'h0); chk("reset_rd0", rd_a[31:0]);
      exp_q.push_back(32'h0); chk("reset_rd1", rd_a[63:32]);
    end
    exp_q.push_back(32'h0); chk("reset_pending", pv_a);
    tick();
    wr(0, 5'd5, 32'hDEADBEEF);
    tick();
    we = '0;
    rreg = {5'd5, 5'd5};
    #1;
    exp_q.push_back(32'hDEADBEEF); chk("r5_port0", rd_a[31:0]);
    exp_q.push_back(32'hDEADBEEF); chk("r5_port1", rd_a[63:32]);
    exp_q.push_back(32'hDEADBEEF); chk("r5_nobyp", rd_b[31:0]);
    tick();
    wr(0, 5'd0, 32'h1);
    tick();
    we = '0;
    rreg = {5'd0, 5'd0};
    #1;
    exp_q.push_back(32'h0); chk("r0_zero", rd_a[31:0]);
    exp_q.push_back(32'h0); chk("r0_dump", dump_a[31:0]);
    tick();
    wr(0, 5'd7, 32'h11);
    wr(1, 5'd7, 32'h22);
    tick();
    we = '0;
    rreg = {5'd7, 5'd7};
    #1;
    exp_q.push_back(32'h22); chk("collide_rd", rd_a[63:32]);
    exp_q.push_back(32'h22); chk("collide_dump", dump_b[7*32 +: 32]);
    tick();
    wr(0, 5'd9, 32'hA5A5);
    rreg = {5'd9, 5'd9};
    #1;
    exp_q.push_back(32'hA5A5); chk("bypass_on", rd_a[31:0]);
    exp_q.push_back(32'h0);    chk("bypass_off", rd_b[31:0]);
    exp_q.push_back(32'h0);    chk("dump_nobyp", dump_a[9*32 +: 32]);
    tick();
    we = '0;
    exp_q.push_back(32'hA5A5); chk("regread_byp", rd_c[31:0]);
    exp_q.push_back(32'hA5A5); chk("r9_stored", rd_b[31:0]);
    rsv = 1'b1; rsv_reg = 5'd3; rreg = {5'd3, 5'd3};
    tick();
    rsv = 1'b0;
    #1;
    exp_q.push_back(32'h8);  chk("reserve_vec", pv_a);
    exp_q.push_back(32'h3);  chk("reserve_rp", {30'h0, rp_a});
    wr(1, 5'd3, 32'h33);
    rsv = 1'b1; rsv_reg = 5'd3;
    #1;
    exp_q.push_back(32'h1);  chk("rsv_wr_rp", {31'h0, rp_a[0]});
    tick();
    we = '0; rsv = 1'b0;
    exp_q.push_back(32'h8);  chk("rsv_wr_vec", pv_a);
    wr(1, 5'd3, 32'h44);
    #1;
    exp_q.push_back(32'h0);  chk("wr_clear_byp_rp", {31'h0, rp_a[0]});
    exp_q.push_back(32'h1);  chk("wr_clear_nobyp_rp", {31'h0, rp_b[0]});
    tick();
    we = '0;
    exp_q.push_back(32'h0);  chk("wr_clear_vec", pv_a);
    exp_q.push_back(32'h44); chk("r3_data", rd_a[31:0]);
    rreg = {5'd7, 5'd7};
    rsv = 1'b1; rsv_reg = 5'd4;
    tick();
    rsv = 1'b0;
    exp_q.push_back(32'h22); chk("regread_r7", rd_c[31:0]);
    exp_q.push_back(32'h10); chk("regread_pend", pv_c);
    wr(0, 5'd12, 32'h1234);
    rreg = {5'd12, 5'd12};
    #2 ctrl_reset = 1'b1;
    #1;
    exp_q.push_back(32'h0); chk("rst_rd_c", rd_c[31:0]);
    exp_q.push_back(32'h0); chk("rst_pend_c", pv_c);
    exp_q.push_back(32'h0); chk("rst_r12", dump_c[12*32 +: 32]);
    exp_q.push_back(32'h0); chk("rst_dump_any", {31'h0, |dump_c});
    exp_q.push_back(32'h0); chk("rst_r7_a", dump_a[7*32 +: 32]);
    we = '0;
    tick();
    #3 ctrl_reset = 1'b0;
    tick();
    exp_q.push_back(32'h0); chk("post_rst_r12_c", rd_c[31:0]);
    exp_q.push_back(32'h0); chk("post_rst_r12_a", rd_a[31:0]);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
